// File: rtl/mem_pkg.sv
// Shared types and decode helpers for the data-memory access stage.
// Latency: none (declarations and pure functions only).
// Backpressure: n/a; consumers own all handshaking.
package mem_pkg;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    // Access size is the low two funct3 bits; 11 never reaches the memory.
    typedef enum logic [1:0] {
        SZ_B    = 2'd0,
        SZ_H    = 2'd1,
        SZ_W    = 2'd2,
        SZ_RSVD = 2'd3
    } access_size_e;

    function automatic access_size_e f3_size(input logic [2:0] f3);
        return access_size_e'(f3[1:0]);
    endfunction

    // Stores have no unsigned variants, so any funct3 with bit2 set is illegal there.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) return !(f3 inside {F3_B, F3_H, F3_W});
        return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3_size(f3))
            SZ_H:    return lo[0];
            SZ_W:    return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] wstrb_of(input access_size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return 4'b0001 << lo;
            SZ_H:    return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Memory-side request/response bus between the access unit and data memory.
// Latency: wires only.
// Backpressure: the memory stalls the unit by holding mem_ready_i low.
interface mem_access_unit_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  mem_rdata_i, mem_ready_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output mem_rdata_i, mem_ready_i
    );
endinterface

// File: rtl/lsu_format.sv
// Byte-lane formatter: store lane replication or load extraction with extension.
// Latency: purely combinational.
// Backpressure: none.
module lsu_format
    import mem_pkg::*;
(
    input  logic         store,
    input  access_size_e size,
    input  logic         sign,
    input  logic [1:0]   lo,
    input  logic [31:0]  data_i,
    output logic [31:0]  data_o
);
    logic [31:0] shifted;

    // Replicate store data across lanes, or pull the addressed lanes down and extend them
    always_comb begin
        shifted = data_i >> {lo, 3'b000};
        data_o  = data_i;
        if (store) begin
            case (size)
                SZ_B:    data_o = {4{data_i[7:0]}};
                SZ_H:    data_o = {2{data_i[15:0]}};
                default: data_o = data_i;
            endcase
        end else begin
            case (size)
                SZ_B:    data_o = {{24{sign & shifted[7]}}, shifted[7:0]};
                SZ_H:    data_o = {{16{sign & shifted[15]}}, shifted[15:0]};
                default: data_o = data_i;
            endcase
        end
    end
endmodule

// File: rtl/mem_access_unit.sv
// RV32I data-memory access stage; optional REQ abort guarded by MEM_TIMEOUT_EN.
// Latency: done_o two cycles after start with a zero-wait memory, one after start on a fault.
// Backpressure: waits in REQ while mem_ready_i is low; busy_o stalls the control FSM.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        illegal_o,
    output logic        timeout_o,
    mem_access_unit_if.master mem
);
    state_t       state, state_nxt;
    logic         we_q;
    logic [2:0]   f3_q;
    logic [31:0]  addr_q;
    logic [31:0]  wdata_q;
    access_size_e sz_q;
    logic [31:0]  st_dat;
    logic [31:0]  ld_dat;
    logic         in_req;
    logic         ill_now;
    logic         mis_now;
    logic         to_hit;

    assign sz_q    = f3_size(f3_q);
    assign in_req  = (state == REQ);
    assign ill_now = f3_illegal(we_i, funct3_i);
    assign mis_now = f3_misaligned(funct3_i, addr_i[1:0]);

    lsu_format u_store_fmt (
        .store  (1'b1),
        .size   (sz_q),
        .sign   (1'b0),
        .lo     (addr_q[1:0]),
        .data_i (wdata_q),
        .data_o (st_dat)
    );

    lsu_format u_load_fmt (
        .store  (1'b0),
        .size   (sz_q),
        .sign   (!f3_q[2]),
        .lo     (addr_q[1:0]),
        .data_i (mem.mem_rdata_i),
        .data_o (ld_dat)
    );

`ifdef MEM_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       timeout_q;

    // Count REQ cycles; held at zero outside REQ so every entry starts fresh
    always_ff @(posedge clk) begin
        if (reset || !in_req) to_cnt <= 8'd0;
        else                  to_cnt <= to_cnt + 8'd1;
    end

    // Abort only when the limit is reached with no ready in the same cycle
    assign to_hit = in_req && !mem.mem_ready_i && (to_cnt == 8'(TIMEOUT - 1));

    // Sticky timeout flag, cleared by the next accepted start
    always_ff @(posedge clk) begin
        if (reset)                         timeout_q <= 1'b0;
        else if (state == IDLE && start_i) timeout_q <= 1'b0;
        else if (to_hit)                   timeout_q <= 1'b1;
    end

    assign timeout_o = timeout_q;
`else
    assign to_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; faults skip the memory and report in a single cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) state_nxt = (ill_now || mis_now) ? FAULT : REQ;
            end
            REQ: begin
                if (mem.mem_ready_i) state_nxt = DONE;
                else if (to_hit)     state_nxt = FAULT;
            end
            DONE:    state_nxt = IDLE;
            FAULT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, fault flags and load result
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            illegal_o    <= 1'b0;
            misaligned_o <= 1'b0;
            rdata_o      <= 32'd0;
        end else begin
            if (state == IDLE && start_i) begin
                we_q         <= we_i;
                f3_q         <= funct3_i;
                addr_q       <= addr_i;
                wdata_q      <= wdata_i;
                illegal_o    <= ill_now;
                misaligned_o <= !ill_now && mis_now;
            end
            if (in_req && mem.mem_ready_i && !we_q) rdata_o <= ld_dat;
        end
    end

    assign busy_o          = (state != IDLE);
    assign done_o          = (state == DONE) || (state == FAULT);
    assign mem.mem_req_o   = in_req;
    assign mem.mem_we_o    = in_req && we_q;
    assign mem.mem_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem.mem_wdata_o = (in_req && we_q) ? st_dat : 32'd0;
    assign mem.mem_wstrb_o = (in_req && we_q) ? wstrb_of(sz_q, addr_q[1:0]) : 4'b0000;
endmodule
